bus_scale_transceiver: RTL and testbench
========================================

// Module: bus_scale_transceiver
// PURPOSE
//  Parametrised bidirectional-bus scaling transceiver. Samples a shared tri-state
//  data bus on write strobes and multiplies each sample by SCALE. Results are queued
//  in a DEPTH-entry FIFO and driven back onto the bus on request, with a guarded
//  turnaround so bus ownership never overlaps. Sits between a bus master and the
//  shared data bus. Adds queueing, saturation and error flags.
// PARAMETERS
//  WIDTH      12  bus/data width in bits
//  DEPTH      4   result FIFO entries (power of 2, >=2)
//  SCALE      5   unsigned multiplier constant (>=1)
//  SATURATE   0   0: truncate product to WIDTH LSBs; 1: clamp to all-ones
//  TURN_CYC   1   idle (Z) cycles before and after each drive window (>=1)
// PORTS
//  clk        in    1      rising-edge clock
//  reset      in    1      asynchronous, active-high reset
//  data_bus   inout WIDTH  shared bus; driven only in DRIVE state, else 'z
//  wr         in    1      write strobe, synchronous to clk; rising edge = sample
//  rd_req     in    1      level request for this block to drive head result
//  clr_err    in    1      synchronous clear of sticky flags
//  bus_oe     out   1      1 while data_bus is driven
//  full       out   1      FIFO holds DEPTH entries
//  empty      out   1      FIFO holds 0 entries
//  ovf_err    out   1      sticky: push attempted while full
//  sat_err    out   1      sticky: product exceeded WIDTH bits
//  col_err    out   1      sticky: wr edge seen while bus_oe or TURN_OFF
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, bus_oe=0, data_bus='z, empty=1, full=0,
//   all err flags=0, wr edge-detect register=0.
//  Sample: wr_q<=wr each clk; edge = wr & ~wr_q. In IDLE/TURN_ON the edge captures
//   data_bus. Product is 2*WIDTH bits, computed as data_bus*SCALE. It is pushed the
//   same clk, so the entry is visible (empty falls) the next cycle.
//  Width: if product[2W-1:W]!=0, set sat_err. The pushed value is product[W-1:0] when
//   SATURATE=0, or {WIDTH{1'b1}} when SATURATE=1.
//  Full: a push while full is dropped. FIFO content is unchanged and ovf_err sets.
//  Collision: an edge in DRIVE or TURN_OFF sets col_err and is not sampled.
//  FSM: IDLE -> TURN_ON when rd_req & ~empty.
//   TURN_ON: bus stays Z for TURN_CYC cycles, then -> DRIVE.
//   DRIVE: bus_oe=1, data_bus=FIFO head (registered output, stable whole window).
//    Stays while rd_req=1. When rd_req=0, pop the head on that edge and -> TURN_OFF.
//   TURN_OFF: Z for TURN_CYC cycles, then -> IDLE.
//   rd_req dropping during TURN_ON: return to IDLE, no pop.
//  Simultaneous push+pop: only possible on the DRIVE exit edge when the edge is
//   flagged as collision, so no push occurs. Count changes by at most 1 per cycle.
//  Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
//  clr_err clears flags. A new error event in the same cycle wins (the flag stays set).
//  Reset asserted mid-DRIVE releases the bus immediately (async) and flushes the FIFO.
// STRUCTURE
//  Package bus_scale_pkg: FSM state enum (IDLE, TURN_ON, DRIVE, TURN_OFF) and a
//   turn-counter width function.
//  Sub-module bst_fifo: synchronous FIFO, params WIDTH/DEPTH, push/pop/full/empty,
//   async active-high reset. The top level holds the FSM, multiplier and tri-state.
// TESTING
//  Reset, then wr edge with bus=12'h003 -> empty=0 next cycle. rd_req -> after 1 Z
//   cycle, bus=12'h00F with bus_oe=1.
//  SATURATE=0, bus=12'h400 -> 12'h400*5 truncates to 12'h400 and sat_err=1.
//   SATURATE=1 -> 12'hFFF and sat_err=1.
//  Push 5 values with DEPTH=4 -> full=1 after 4, ovf_err=1. Read 4 back in push
//   order, then empty=1.
//  wr edge while bus_oe=1 -> col_err=1 and FIFO count unchanged. clr_err -> flag=0.
//  rd_req held 3 cycles in DRIVE -> same value all 3 cycles, exactly one pop.
//   rd_req pulse dropped in TURN_ON -> no pop, bus never driven.
//  Assert reset during DRIVE -> data_bus='z same cycle, empty=1, all flags=0.

Source files
------------

// File: rtl/bus_scale_pkg.sv
// Shared types and helpers for the bus scaling transceiver.
package bus_scale_pkg;

  // Bus ownership phases: idle listening, guarded turn-on, active drive, guarded turn-off.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } bst_state_e;

  // The turn counter runs from 0 to turnCyc-1, so it needs clog2(turnCyc) bits, at least 1.
  function automatic int turnCntWidth(input int turnCyc);
    return (turnCyc < 2) ? 1 : $clog2(turnCyc);
  endfunction

endpackage

// File: rtl/bus_scale_transceiver_if.sv
// Handshake and status bundle between a bus master and the scaling transceiver.
interface bus_scale_transceiver_if;

  logic wr;
  logic rd_req;
  logic clr_err;
  logic bus_oe;
  logic full;
  logic empty;
  logic ovf_err;
  logic sat_err;
  logic col_err;

  modport master (
    output wr, rd_req, clr_err,
    input  bus_oe, full, empty, ovf_err, sat_err, col_err
  );

  modport slave (
    input  wr, rd_req, clr_err,
    output bus_oe, full, empty, ovf_err, sat_err, col_err
  );

endinterface

// File: rtl/bst_fifo.sv
// Small synchronous result FIFO; head word is always presented on head_o.
module bst_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q];

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bus_scale_transceiver.sv
// Samples the shared bus on wr edges, scales by SCALE, queues results and
// drives them back with idle turnaround cycles around each drive window.
module bus_scale_transceiver
  import bus_scale_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 4,
  parameter int SCALE    = 5,
  parameter int SATURATE = 0,
  parameter int TURN_CYC = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  inout  wire  [WIDTH-1:0]       data_bus_io,
  bus_scale_transceiver_if.slave bus_if
);

  localparam int CW = turnCntWidth(TURN_CYC);
  localparam logic [CW-1:0] TurnLast = CW'(TURN_CYC - 1);
  localparam logic [2*WIDTH-1:0] ScaleWide = (2 * WIDTH)'(SCALE);

  bst_state_e       state_q, state_d;
  logic [CW-1:0]    turnCnt_q, turnCnt_d;
  logic             wr_q;
  logic             busOe_q;
  logic [WIDTH-1:0] driveData_q;
  logic             ovfErr_q, satErr_q, colErr_q;

  logic             wrEdge;
  logic             sampleWin;
  logic             pushReq;
  logic             pushOk;
  logic             pop;
  logic             overRange;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] pushData;
  logic [WIDTH-1:0] headData;
  logic             fifoFull;
  logic             fifoEmpty;

  assign wrEdge    = bus_if.wr & ~wr_q;
  assign sampleWin = (state_q == IDLE) || (state_q == TURN_ON);
  assign pushReq   = wrEdge & sampleWin;
  assign pushOk    = pushReq & ~fifoFull;
  assign product   = (2 * WIDTH)'(data_bus_io) * ScaleWide;
  assign overRange = |product[2*WIDTH-1:WIDTH];
  assign pushData  = ((SATURATE != 0) && overRange) ? {WIDTH{1'b1}} : product[WIDTH-1:0];

  bst_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (pushOk),
    .data_i  (pushData),
    .pop_i   (pop),
    .head_o  (headData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Next-state logic: a drive window opens only after the turn-on guard and closes with a pop.
  always_comb begin
    state_d   = state_q;
    turnCnt_d = turnCnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_if.rd_req && !fifoEmpty) begin
          state_d   = TURN_ON;
          turnCnt_d = '0;
        end
      end
      TURN_ON: begin
        if (!bus_if.rd_req) begin
          state_d = IDLE;
        end else if (turnCnt_q == TurnLast) begin
          state_d = DRIVE;
        end else begin
          turnCnt_d = turnCnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (!bus_if.rd_req) begin
          pop       = 1'b1;
          state_d   = TURN_OFF;
          turnCnt_d = '0;
        end
      end
      TURN_OFF: begin
        if (turnCnt_q == TurnLast) begin
          state_d = IDLE;
        end else begin
          turnCnt_d = turnCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, edge detector and the registered drive window; reset drops the bus at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      turnCnt_q   <= '0;
      wr_q        <= 1'b0;
      busOe_q     <= 1'b0;
      driveData_q <= '0;
    end else begin
      state_q   <= state_d;
      turnCnt_q <= turnCnt_d;
      wr_q      <= bus_if.wr;
      busOe_q   <= (state_d == DRIVE);
      if ((state_q != DRIVE) && (state_d == DRIVE)) begin
        driveData_q <= headData;
      end
    end
  end

  // Sticky error flags; a fresh event outranks a clear in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovfErr_q <= 1'b0;
      satErr_q <= 1'b0;
      colErr_q <= 1'b0;
    end else begin
      ovfErr_q <= (ovfErr_q & ~bus_if.clr_err) | (pushReq & fifoFull);
      satErr_q <= (satErr_q & ~bus_if.clr_err) | (pushReq & overRange);
      colErr_q <= (colErr_q & ~bus_if.clr_err) | (wrEdge & ~sampleWin);
    end
  end

  assign data_bus_io    = busOe_q ? driveData_q : {WIDTH{1'bz}};
  assign bus_if.bus_oe  = busOe_q;
  assign bus_if.full    = fifoFull;
  assign bus_if.empty   = fifoEmpty;
  assign bus_if.ovf_err = ovfErr_q;
  assign bus_if.sat_err = satErr_q;
  assign bus_if.col_err = colErr_q;

endmodule

// File: tb/tb_bus_scale_transceiver.sv
// Directed bench for bus_scale_transceiver: one truncating and one saturating instance.
module tb_bus_scale_transceiver;

  logic        clk;
  logic        reset;
  logic        tbOe;
  logic [11:0] tbData;
  wire  [11:0] dataBus;
  wire  [11:0] dataBusS;
  int          assertCount;
  int          failCount;

  bus_scale_transceiver_if mainIf ();
  bus_scale_transceiver_if satIf ();

  assign dataBus  = tbOe ? tbData : 12'bz;
  assign dataBusS = tbOe ? tbData : 12'bz;

  bus_scale_transceiver #(
    .WIDTH (12), .DEPTH (4), .SCALE (5), .SATURATE (0), .TURN_CYC (1)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .data_bus_io (dataBus),
    .bus_if      (mainIf)
  );

  bus_scale_transceiver #(
    .WIDTH (12), .DEPTH (4), .SCALE (5), .SATURATE (1), .TURN_CYC (1)
  ) dutSat (
    .clk_i       (clk),
    .reset_i     (reset),
    .data_bus_io (dataBusS),
    .bus_if      (satIf)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One wr edge on the main instance with the given bus value.
  task automatic applyStimulus(input logic [11:0] value);
    tbData    = value;
    tbOe      = 1'b1;
    mainIf.wr = 1'b1;
    tick();
    mainIf.wr = 1'b0;
    tbOe      = 1'b0;
    tick();
  endtask

  // Full read window on the main instance, checking the driven head value.
  task automatic readResult(input string tag, input logic [11:0] exp);
    mainIf.rd_req = 1'b1;
    tick();
    tick();
    checkOutput({tag, "_oe"}, 32'(mainIf.bus_oe), 32'h1);
    checkOutput(tag, 32'(dataBus), 32'(exp));
    mainIf.rd_req = 1'b0;
    tick();
    tick();
  endtask

  // Same read window on the saturating instance.
  task automatic readResultSat(input string tag, input logic [11:0] exp);
    satIf.rd_req = 1'b1;
    tick();
    tick();
    checkOutput({tag, "_oe"}, 32'(satIf.bus_oe), 32'h1);
    checkOutput(tag, 32'(dataBusS), 32'(exp));
    satIf.rd_req = 1'b0;
    tick();
    tick();
  endtask

  // Directed sequence of scenarios.
  initial begin
    assertCount    = 0;
    failCount      = 0;
    reset          = 1'b1;
    tbOe           = 1'b0;
    tbData         = '0;
    mainIf.wr      = 1'b0;
    mainIf.rd_req  = 1'b0;
    mainIf.clr_err = 1'b0;
    satIf.wr       = 1'b0;
    satIf.rd_req   = 1'b0;
    satIf.clr_err  = 1'b0;
    tick();
    tick();

    checkOutput("rst_empty", 32'(mainIf.empty), 32'h1);
    checkOutput("rst_full", 32'(mainIf.full), 32'h0);
    checkOutput("rst_oe", 32'(mainIf.bus_oe), 32'h0);
    checkOutput("rst_flags", {29'd0, mainIf.ovf_err, mainIf.sat_err, mainIf.col_err}, 32'h0);
    reset = 1'b0;
    tick();

    // Basic scale 3*5 and 7*5; hold rd_req three drive cycles, exactly one pop.
    tbData    = 12'h003;
    tbOe      = 1'b1;
    mainIf.wr = 1'b1;
    tick();
    checkOutput("push_empty", 32'(mainIf.empty), 32'h0);
    mainIf.wr = 1'b0;
    tbOe      = 1'b0;
    tick();
    applyStimulus(12'h007);
    mainIf.rd_req = 1'b1;
    tick();
    checkOutput("turnon_z", 32'(mainIf.bus_oe), 32'h0);
    tick();
    checkOutput("drive_oe", 32'(mainIf.bus_oe), 32'h1);
    checkOutput("drive_c1", 32'(dataBus), 32'h00F);
    tick();
    checkOutput("drive_c2", 32'(dataBus), 32'h00F);
    tick();
    checkOutput("drive_c3", 32'(dataBus), 32'h00F);
    mainIf.rd_req = 1'b0;
    tick();
    checkOutput("turnoff_z", 32'(mainIf.bus_oe), 32'h0);
    checkOutput("one_pop", 32'(mainIf.empty), 32'h0);
    tick();
    readResult("second", 12'h023);
    checkOutput("drain_empty", 32'(mainIf.empty), 32'h1);

    // rd_req pulse dropped during turn-on: no drive, no pop.
    applyStimulus(12'h010);
    mainIf.rd_req = 1'b1;
    tick();
    checkOutput("abort_z1", 32'(mainIf.bus_oe), 32'h0);
    mainIf.rd_req = 1'b0;
    tick();
    checkOutput("abort_z2", 32'(mainIf.bus_oe), 32'h0);
    tick();
    checkOutput("abort_z3", 32'(mainIf.bus_oe), 32'h0);
    checkOutput("abort_nopop", 32'(mainIf.empty), 32'h0);

    // Collision: wr edge while driving is flagged and not queued.
    applyStimulus(12'h001);
    mainIf.rd_req = 1'b1;
    tick();
    tick();
    checkOutput("col_drive", 32'(dataBus), 32'h050);
    mainIf.wr = 1'b1;
    tick();
    checkOutput("col_flag", 32'(mainIf.col_err), 32'h1);
    checkOutput("col_oe", 32'(mainIf.bus_oe), 32'h1);
    mainIf.wr     = 1'b0;
    mainIf.rd_req = 1'b0;
    tick();
    tick();
    checkOutput("col_left1", 32'(mainIf.empty), 32'h0);
    readResult("col_next", 12'h005);
    checkOutput("col_nopush", 32'(mainIf.empty), 32'h1);
    mainIf.clr_err = 1'b1;
    tick();
    mainIf.clr_err = 1'b0;
    checkOutput("col_clr", 32'(mainIf.col_err), 32'h0);

    // Fill to DEPTH, overflow push dropped, read back in order.
    applyStimulus(12'h001);
    applyStimulus(12'h002);
    applyStimulus(12'h003);
    checkOutput("fill3_full", 32'(mainIf.full), 32'h0);
    applyStimulus(12'h004);
    checkOutput("fill4_full", 32'(mainIf.full), 32'h1);
    checkOutput("fill4_ovf", 32'(mainIf.ovf_err), 32'h0);
    applyStimulus(12'h100);
    checkOutput("ovf_flag", 32'(mainIf.ovf_err), 32'h1);
    checkOutput("ovf_full", 32'(mainIf.full), 32'h1);
    readResult("rd0", 12'h005);
    readResult("rd1", 12'h00A);
    readResult("rd2", 12'h00F);
    readResult("rd3", 12'h014);
    checkOutput("rd_empty", 32'(mainIf.empty), 32'h1);
    mainIf.clr_err = 1'b1;
    tick();
    mainIf.clr_err = 1'b0;
    checkOutput("ovf_clr", 32'(mainIf.ovf_err), 32'h0);

    // Truncating instance: 0x400*5 = 0x1400 keeps low bits 0x400.
    applyStimulus(12'h400);
    checkOutput("trunc_sat", 32'(mainIf.sat_err), 32'h1);
    readResult("trunc_val", 12'h400);

    // Saturating instance: 0x333*5 = 0xFFF fits exactly, 0x400 clamps.
    tbData   = 12'h333;
    tbOe     = 1'b1;
    satIf.wr = 1'b1;
    tick();
    satIf.wr = 1'b0;
    tbOe     = 1'b0;
    tick();
    checkOutput("sat_exact_flag", 32'(satIf.sat_err), 32'h0);
    tbData   = 12'h400;
    tbOe     = 1'b1;
    satIf.wr = 1'b1;
    tick();
    satIf.wr = 1'b0;
    tbOe     = 1'b0;
    tick();
    checkOutput("sat_flag", 32'(satIf.sat_err), 32'h1);
    readResultSat("sat_exact", 12'hFFF);
    readResultSat("sat_clamp", 12'hFFF);
    checkOutput("sat_empty", 32'(satIf.empty), 32'h1);

    // Reset mid-drive releases the bus immediately and flushes everything.
    applyStimulus(12'h002);
    applyStimulus(12'h006);
    mainIf.rd_req = 1'b1;
    tick();
    tick();
    checkOutput("pre_rst_oe", 32'(mainIf.bus_oe), 32'h1);
    checkOutput("pre_rst_val", 32'(dataBus), 32'h00A);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_oe", 32'(mainIf.bus_oe), 32'h0);
    checkOutput("arst_empty", 32'(mainIf.empty), 32'h1);
    checkOutput("arst_flags", {29'd0, mainIf.ovf_err, mainIf.sat_err, mainIf.col_err}, 32'h0);
    mainIf.rd_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst_oe", 32'(mainIf.bus_oe), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
